segre_icache: RTL and testbench
===============================

SEGRE_ICACHE -- requirements
Module: segre_icache

Interface
REQ-001 Parameter NUM_LINES, default 4, number of direct-mapped lines (power of two, >=2).
REQ-002 Parameter LINE_W, default 128, line width in bits, equal to the memory model's returned cache line.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rsn_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  core fetch request.
REQ-006 addr_i  input  32  core fetch byte address; bits [1:0] ignored.
REQ-007 flush_i  input  1  invalidate all lines.
REQ-008 rd_data_o  output  32  fetched instruction word.
REQ-009 ready_o  output  1  rd_data_o valid for the current addr_i.
REQ-010 mem_rd_o  output  1  line refill request to memory.
REQ-011 mem_addr_o  output  32  line-aligned refill address (low log2(LINE_W/8) bits zero).
REQ-012 mem_ready_i  input  1  memory line return strobe.
REQ-013 mem_line_i  input  LINE_W  returned line.
REQ-014 hit_cnt_o / miss_cnt_o  output  32 each  saturating hit and miss counters.

Function
REQ-015 Address split: offset = addr_i[3:0] (word select [3:2]), index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-016 Storage: per line a valid bit, tag register, LINE_W data register; no byte enables, read-only cache.
REQ-017 FSM states IDLE, REFILL; reset state IDLE.
REQ-018 IDLE, req_i=1, valid[index] and tag match: hit; ready_o=1 combinationally in the same cycle, rd_data_o = selected word of the line.
REQ-019 IDLE, req_i=1, miss: ready_o=0, next state REFILL, refill address latched as {addr_i tag,index, zero offset}.
REQ-020 REFILL: mem_rd_o=1 and mem_addr_o = latched address every cycle until mem_ready_i=1.
REQ-021 REFILL and mem_ready_i=1: write mem_line_i, tag, valid=1 into the latched index at that edge; next state IDLE; mem_rd_o deasserts the following cycle.
REQ-022 After refill the held request hits in IDLE one cycle after the mem_ready_i edge; minimum miss latency = memory latency + 1 cycle.
REQ-023 The core holds addr_i and req_i stable from request until ready_o=1; behaviour otherwise is undefined except that no illegal state is entered.
REQ-024 ready_o is 0 whenever req_i=0 or FSM is in REFILL; rd_data_o is don't-care when ready_o=0.
REQ-025 mem_rd_o=0 and mem_addr_o=0 in IDLE.
REQ-026 flush_i=1 in IDLE: all valid bits cleared at the edge; hit detection in that same cycle is suppressed (ready_o=0).
REQ-027 flush_i=1 in REFILL: request stays asserted; incoming line is written but its valid bit is left 0; return to IDLE and the held request misses again.
REQ-028 hit_cnt_o increments once per hit cycle with req_i=1; miss_cnt_o increments once per IDLE->REFILL transition; both saturate at 32'hFFFF_FFFF, no wrap.
REQ-029 Replacement: the missed index is always overwritten (direct-mapped, no victim logic).

Reset
REQ-030 rsn_i=0 forces, asynchronously: FSM IDLE, all valid bits 0, mem_rd_o=0, mem_addr_o=0, ready_o=0, counters 0.
REQ-031 Reset during REFILL abandons the refill; a later mem_ready_i in IDLE is ignored.
REQ-032 Tag and data arrays need no reset.

Structure
REQ-033 segre_pkg holds: LINE_W default, word/offset/index widths, icache_state_t enum (IDLE, REFILL).
REQ-034 One sub-module, segre_icache_tags (valid+tag array with lookup/hit output); data array and FSM stay in segre_icache.
REQ-035 segre_icache sits between the core fetch port and the memory model in segre_soc; the data path is unchanged.

Verification
REQ-036 Cold miss: reset, req_i=1 addr 0x0000_0104, memory returns line 0x4444_3333_2222_1111 pattern after 3 cycles -> mem_rd_o high 3 cycles, mem_addr_o=0x100, ready_o=1 with rd_data_o=0x2222_2222 (word 1) one cycle later, miss_cnt_o=1.
REQ-037 Hit: then addr 0x0000_010C -> ready_o=1 same cycle, rd_data_o = word 3, hit_cnt_o increments, mem_rd_o stays 0.
REQ-038 Conflict: addr 0x0000_0144 (same index 0, tag differs, NUM_LINES=4) -> miss, refill at 0x140, then 0x104 misses again.
REQ-039 Flush: line cached, flush_i pulse -> next access to the same address misses; flush during REFILL -> held request re-misses, miss_cnt_o=2.
REQ-040 Reset mid-refill: rsn_i low while mem_rd_o=1 -> mem_rd_o drops without a clock edge; stale mem_ready_i afterwards writes nothing (address misses).
REQ-041 Counter saturation: force hit_cnt_o to 0xFFFF_FFFE, issue 3 hits -> reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/segre_icache_pkg.sv
// Shared constants, FSM state type and helpers for the direct-mapped instruction cache.
package segre_pkg;

    localparam int ADDR_W        = 32;
    localparam int WORD_W        = 32;
    localparam int LINE_W_DEF    = 128;
    localparam int NUM_LINES_DEF = 4;

    // Byte offset inside a line, word select inside a line, line index.
    localparam int OFFSET_W = $clog2(LINE_W_DEF / 8);
    localparam int WSEL_W   = $clog2(LINE_W_DEF / WORD_W);
    localparam int INDEX_W  = $clog2(NUM_LINES_DEF);

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/segre_icache_if.sv
// Core fetch port plus memory refill port of the instruction cache.
interface segre_icache_if
    import segre_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF
);
    logic              req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              flush_i;
    logic [WORD_W-1:0] rd_data_o;
    logic              ready_o;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ready_i;
    logic [LINE_W-1:0] mem_line_i;

    // Core + memory side: drives requests and returned lines.
    modport master (
        output req_i, addr_i, flush_i, mem_ready_i, mem_line_i,
        input  rd_data_o, ready_o, mem_rd_o, mem_addr_o
    );

    // Cache side.
    modport slave (
        input  req_i, addr_i, flush_i, mem_ready_i, mem_line_i,
        output rd_data_o, ready_o, mem_rd_o, mem_addr_o
    );
endinterface

// File: rtl/segre_icache_tags.sv
// Valid bits and tag array with a single combinational lookup port.
module segre_icache_tags #(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 26
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] lkp_idx_i,
    input  logic [TAG_W-1:0] lkp_tag_i,
    output logic             hit_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i
);

    logic [NUM_LINES-1:0]            valid_q;
    logic [NUM_LINES-1:0][TAG_W-1:0] tag_q;

    // Valid bits: flush wins over a same-cycle fill so a line landing during a flush stays invalid.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag storage has no reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;
    end

    assign hit_o = valid_q[lkp_idx_i] && (tag_q[lkp_idx_i] == lkp_tag_i);

endmodule

// File: rtl/segre_icache.sv
// Direct-mapped, read-only instruction cache between the core fetch port and memory.
module segre_icache
    import segre_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int LINE_W    = LINE_W_DEF
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    segre_icache_if.slave bus,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int OFF_W  = (LINE_W == LINE_W_DEF) ? OFFSET_W : $clog2(LINE_W / 8);
    localparam int WS_W   = (LINE_W == LINE_W_DEF) ? WSEL_W : $clog2(LINE_W / WORD_W);
    localparam int IDX_W  = (NUM_LINES == NUM_LINES_DEF) ? INDEX_W : $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int LADR_W = ADDR_W - OFF_W;

    icache_state_t state_q, state_d;

    logic [NUM_LINES-1:0][WORDS-1:0][WORD_W-1:0] data_q;
    logic [LADR_W-1:0] refill_line_q;
    logic [31:0]       hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0] idx, refill_idx;
    logic [TAG_W-1:0] tag, refill_tag;
    logic [WS_W-1:0]  wsel;
    logic             tag_hit, hit, miss, refill_done;
    logic             unused_addr_bits;

    assign idx        = bus.addr_i[OFF_W +: IDX_W];
    assign tag        = bus.addr_i[ADDR_W-1 -: TAG_W];
    assign wsel       = bus.addr_i[OFF_W-1 -: WS_W];
    assign refill_idx = refill_line_q[IDX_W-1:0];
    assign refill_tag = refill_line_q[LADR_W-1 -: TAG_W];

    assign unused_addr_bits = ^bus.addr_i[1:0];

    segre_icache_tags #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_tags (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .flush_i   (bus.flush_i),
        .lkp_idx_i (idx),
        .lkp_tag_i (tag),
        .hit_o     (tag_hit),
        .wr_en_i   (refill_done),
        .wr_idx_i  (refill_idx),
        .wr_tag_i  (refill_tag)
    );

    // State register; reset abandons any refill in flight.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and memory-side outputs; a flushing cycle neither hits nor starts a refill.
    always_comb begin
        state_d        = state_q;
        hit            = 1'b0;
        miss           = 1'b0;
        refill_done    = 1'b0;
        bus.mem_rd_o   = 1'b0;
        bus.mem_addr_o = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_i && !bus.flush_i) begin
                    if (tag_hit) begin
                        hit = 1'b1;
                    end else begin
                        miss    = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                bus.mem_rd_o   = 1'b1;
                bus.mem_addr_o = {refill_line_q, {OFF_W{1'b0}}};
                if (bus.mem_ready_i) begin
                    refill_done = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the line address of the missing fetch.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i)    refill_line_q <= '0;
        else if (miss) refill_line_q <= bus.addr_i[ADDR_W-1:OFF_W];
    end

    // Line data is written whole on refill; no reset needed.
    always_ff @(posedge clk_i) begin
        if (refill_done) data_q[refill_idx] <= bus.mem_line_i;
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit)  hit_cnt_q  <= sat_inc(hit_cnt_q);
            if (miss) miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign bus.ready_o   = hit;
    assign bus.rd_data_o = data_q[idx][wsel];
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_segre_icache.sv
// Directed bench for segre_icache: misses, hits, conflicts, flushes, reset and counters.
module tb_segre_icache;
    import segre_pkg::*;

    localparam int LINE_W = 128;
    localparam logic [LINE_W-1:0] LINE_A = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [LINE_W-1:0] LINE_B = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};

    logic        clk_i;
    logic        rsn_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;
    int          n_checks = 0;
    int          n_errors = 0;

    segre_icache_if #(.LINE_W(LINE_W)) bus ();

    segre_icache #(.NUM_LINES(4), .LINE_W(LINE_W)) dut (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .bus        (bus),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits for the refill request, serves it after lat cycles, returns at negedge+1 after the fill edge.
    task automatic do_refill(input logic [31:0] exp_addr, input int lat, input logic [LINE_W-1:0] line);
        int guard = 0;
        while (!bus.mem_rd_o && guard < 20) begin
            @(negedge clk_i); #1;
            guard++;
        end
        if (!bus.mem_rd_o) begin
            chk("refill_start_timeout", 32'(bus.mem_rd_o), 32'd1);
            return;
        end
        for (int n = 1; n <= lat; n++) begin
            chk("refill_rd", 32'(bus.mem_rd_o), 32'd1);
            chk("refill_addr", bus.mem_addr_o, exp_addr);
            if (n == lat) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_line_i  = line;
            end
            @(negedge clk_i); #1;
        end
        bus.mem_ready_i = 1'b0;
        chk("refill_end_rd", 32'(bus.mem_rd_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rsn_i           = 1'b0;
        bus.req_i       = 1'b0;
        bus.addr_i      = '0;
        bus.flush_i     = 1'b0;
        bus.mem_ready_i = 1'b0;
        bus.mem_line_i  = '0;
        #12;
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_miss_cnt", miss_cnt_o, 32'd0);
        @(negedge clk_i) rsn_i = 1'b1;

        // Cold miss, 3-cycle memory
        @(negedge clk_i);
        bus.req_i = 1'b1; bus.addr_i = 32'h0000_0104; #1;
        chk("cold_ready0", 32'(bus.ready_o), 32'd0);
        do_refill(32'h0000_0100, 3, LINE_A);
        chk("cold_ready", 32'(bus.ready_o), 32'd1);
        chk("cold_data", bus.rd_data_o, 32'h2222_2222);
        chk("cold_miss_cnt", miss_cnt_o, 32'd1);
        chk("cold_hit_cnt", hit_cnt_o, 32'd0);

        // Hit in same line, word 3
        @(negedge clk_i);
        bus.addr_i = 32'h0000_010C; #1;
        chk("hit_ready", 32'(bus.ready_o), 32'd1);
        chk("hit_data", bus.rd_data_o, 32'h4444_4444);
        chk("hit_mem_rd", 32'(bus.mem_rd_o), 32'd0);
        @(negedge clk_i); #1;
        chk("hit_cnt2", hit_cnt_o, 32'd2);

        // Conflict on index 0
        bus.addr_i = 32'h0000_0144; #1;
        chk("conf_ready0", 32'(bus.ready_o), 32'd0);
        do_refill(32'h0000_0140, 2, LINE_B);
        chk("conf_ready", 32'(bus.ready_o), 32'd1);
        chk("conf_data", bus.rd_data_o, 32'h6666_6666);
        chk("conf_miss_cnt", miss_cnt_o, 32'd2);
        bus.addr_i = 32'h0000_0104; #1;
        chk("conf_remiss", 32'(bus.ready_o), 32'd0);
        do_refill(32'h0000_0100, 1, LINE_A);
        chk("conf_back_data", bus.rd_data_o, 32'h2222_2222);
        chk("conf_miss_cnt3", miss_cnt_o, 32'd3);
        bus.req_i = 1'b0; #1;
        chk("noreq_ready", 32'(bus.ready_o), 32'd0);

        // Flush in IDLE suppresses the same-cycle hit, then the line misses
        @(negedge clk_i);
        bus.req_i = 1'b1; bus.addr_i = 32'h0000_0104; bus.flush_i = 1'b1; #1;
        chk("flush_supp", 32'(bus.ready_o), 32'd0);
        @(negedge clk_i);
        bus.flush_i = 1'b0; #1;
        chk("flush_miss", 32'(bus.ready_o), 32'd0);
        do_refill(32'h0000_0100, 2, LINE_A);
        chk("flush_refill_ready", 32'(bus.ready_o), 32'd1);
        chk("flush_miss_cnt", miss_cnt_o, 32'd4);

        // Flush during REFILL: line lands invalid, held request misses again
        bus.addr_i = 32'h0000_0118; #1;
        chk("fr_ready0", 32'(bus.ready_o), 32'd0);
        @(negedge clk_i); #1;
        chk("fr_addr", bus.mem_addr_o, 32'h0000_0110);
        bus.flush_i = 1'b1; bus.mem_ready_i = 1'b1; bus.mem_line_i = LINE_B; #1;
        chk("fr_rd_held", 32'(bus.mem_rd_o), 32'd1);
        @(negedge clk_i);
        bus.flush_i = 1'b0; bus.mem_ready_i = 1'b0; #1;
        chk("fr_remiss", 32'(bus.ready_o), 32'd0);
        chk("fr_miss_cnt", miss_cnt_o, 32'd5);
        do_refill(32'h0000_0110, 1, LINE_B);
        chk("fr_data", bus.rd_data_o, 32'h7777_7777);
        chk("fr_miss_cnt2", miss_cnt_o, 32'd6);
        chk("fr_hit_cnt", hit_cnt_o, 32'd2);
        bus.req_i = 1'b0;

        // Reset in the middle of a refill
        @(negedge clk_i);
        bus.req_i = 1'b1; bus.addr_i = 32'h0000_0124; #1;
        @(negedge clk_i); #1;
        chk("mr_rd_before", 32'(bus.mem_rd_o), 32'd1);
        rsn_i = 1'b0; #1;
        chk("mr_rd_async", 32'(bus.mem_rd_o), 32'd0);
        chk("mr_addr_async", bus.mem_addr_o, 32'd0);
        chk("mr_miss_cnt", miss_cnt_o, 32'd0);
        bus.req_i = 1'b0;
        @(negedge clk_i) rsn_i = 1'b1;
        bus.mem_ready_i = 1'b1; bus.mem_line_i = LINE_B;
        @(negedge clk_i);
        bus.mem_ready_i = 1'b0;
        bus.req_i = 1'b1; #1;
        chk("mr_stale_miss", 32'(bus.ready_o), 32'd0);
        do_refill(32'h0000_0120, 1, LINE_A);
        chk("mr_data", bus.rd_data_o, 32'h2222_2222);
        chk("mr_miss_cnt1", miss_cnt_o, 32'd1);

        // Hit counter saturation
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_q;
        @(negedge clk_i); #1;
        chk("sat_hit1", hit_cnt_o, 32'hFFFF_FFFF);
        @(negedge clk_i);
        @(negedge clk_i);
        bus.req_i = 1'b0; #1;
        chk("sat_hit3", hit_cnt_o, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
